uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first: the receive counterpart of the team's UART transmitter, using the same CLKS_PER_BIT timing. It synchronises the raw line, validates the start bit at mid-bit, samples 8 data bits and the stop bit at bit centres, then presents the byte with a one-cycle ready strobe. It sits between the board RX pin and the command/decode logic, alongside the transmitter.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx.sv | 117 +++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, widths and one-hot receiver state encoding
package uart_pkg;

  localparam int UART_CNT_W  = 14;
  localparam int UART_DATA_W = 8;

  // One-hot so that any multi-hot or all-zero value is caught by the FSM default arm
  typedef enum logic [4:0] {
    STATE_IDLE    = 5'b00001,
    STATE_START   = 5'b00010,
    STATE_DATA    = 5'b00100,
    STATE_STOP    = 5'b01000,
    STATE_CLEANUP = 5'b10000
  } uart_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for an asynchronous single-bit input
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  // First flop may go metastable; second flop gives a settled copy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      o_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; define UART_RX_MAJORITY_EN for 2-of-3 sample voting
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rx,
  output logic [UART_DATA_W-1:0] o_rx_byte,
  output logic                   o_rx_byte_rdy,
  output logic                   o_rx_busy,
  output logic                   o_frame_err
);

  localparam logic [UART_CNT_W-1:0] HALF = UART_CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [UART_CNT_W-1:0] LAST = UART_CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e            r_state;
  logic [UART_CNT_W-1:0]  r_count;
  logic [2:0]             r_bit_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   r_armed;
  logic                   rx_s;
  logic                   sample;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  // Last two synchronised values, so a decision at count N sees counts N-2 and N-1
  always_ff @(posedge i_clk) begin
    if (i_rst) r_hist <= 2'b11;
    else       r_hist <= {r_hist[0], rx_s};
  end

  assign sample = majority3(rx_s, r_hist[0], r_hist[1]);
`else
  assign sample = rx_s;
`endif

  assign o_rx_busy = (r_state != STATE_IDLE);

  // Frame sequencer: start validation, bit-centre sampling, registered result pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= STATE_IDLE;
      r_count       <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_armed       <= 1'b0;
      o_rx_byte     <= '0;
      o_rx_byte_rdy <= 1'b0;
      o_frame_err   <= 1'b0;
    end else begin
      o_rx_byte_rdy <= 1'b0;
      o_frame_err   <= 1'b0;
      case (r_state)
        STATE_IDLE: begin
          r_count   <= '0;
          r_bit_idx <= '0;
          // A break after a framing error must be released before the next start
          if (rx_s) r_armed <= 1'b1;
          if (r_armed && !rx_s) r_state <= STATE_START;
        end
        STATE_START: begin
          if (r_count == HALF) begin
            r_count <= '0;
            r_state <= sample ? STATE_IDLE : STATE_DATA;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        STATE_DATA: begin
          if (r_count == LAST) begin
            r_count            <= '0;
            r_shift[r_bit_idx] <= sample;
            r_bit_idx          <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= STATE_STOP;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        STATE_STOP: begin
          if (r_count == LAST) begin
            r_count <= '0;
            if (sample) begin
              o_rx_byte     <= r_shift;
              o_rx_byte_rdy <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
              r_armed     <= 1'b0;
            end
            r_state <= STATE_CLEANUP;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        STATE_CLEANUP: begin
          r_state <= STATE_IDLE;
        end
        default: begin
          r_state   <= STATE_IDLE;
          r_count   <= '0;
          r_bit_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a frame-level reference model
module tb_uart_rx;

  localparam int C    = 16;
  localparam int HALF = (C - 1) / 2;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_byte;
  logic       rdy;
  logic       busy;
  logic       ferr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  last_good;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rx          (rx),
    .o_rx_byte     (rx_byte),
    .o_rx_byte_rdy (rdy),
    .o_rx_busy     (busy),
    .o_frame_err   (ferr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ev(input logic kind, input logic [7:0] b, input int t);
    return {23'd0, kind, b, 32'(t)};
  endfunction

  always @(negedge clk) begin
    if (rdy)  got_q.push_back(ev(1'b0, rx_byte, cyc));
    if (ferr) got_q.push_back(ev(1'b1, 8'h00, cyc));
    if (rdy || ferr) chk("pulse_exclusive", 64'(rdy & ferr), 64'd0);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  // Transmitter model: frame starts in the current cycle f; result expected at f+2+HALF+9C+2
  task automatic send(input logic [7:0] d, input logic stop, input int glitch_bit, input int ncyc);
    int          f;
    int          n;
    logic [9:0]  frame;
    logic [7:0]  want;
    logic        lvl;
    f     = cyc;
    frame = {stop, d, 1'b0};
    want  = d;
`ifndef UART_RX_MAJORITY_EN
    if (glitch_bit >= 0) want[glitch_bit] = ~want[glitch_bit];
`endif
    n = (ncyc < FRAME) ? ncyc : FRAME;
    if (ncyc >= FRAME) begin
      if (stop) begin
        exp_q.push_back(ev(1'b0, want, f + HALF + 9 * C + 4));
        last_good = want;
      end else begin
        exp_q.push_back(ev(1'b1, 8'h00, f + HALF + 9 * C + 4));
      end
    end
    for (int i = 0; i < n; i++) begin
      lvl = frame[i / C];
      if (glitch_bit >= 0 && i == HALF + (glitch_bit + 1) * C + 1) lvl = ~lvl;
      rx = lvl;
      tick(1);
    end
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int         busy_cnt;
    int         perm[256];
    int         j;
    int         tmp;
    logic [7:0] d;
    int         k;

    rst = 1'b1;
    rx  = 1'b1;
    last_good = 8'h00;
    tick(3);
    chk("rst_byte", 64'(rx_byte), 64'h00);
    chk("rst_rdy",  64'(rdy),     64'd0);
    chk("rst_busy", 64'(busy),    64'd0);
    chk("rst_ferr", 64'(ferr),    64'd0);
    rst = 1'b0;
    idle(2 * C);

    send(8'hA5, 1'b1, -1, FRAME);
    idle(C);
    check_events("single");
    chk("single_busy", 64'(busy), 64'd0);
    chk("single_byte", 64'(rx_byte), 64'hA5);

    send(8'h00, 1'b1, -1, FRAME);
    send(8'hFF, 1'b1, -1, FRAME);
    send(8'h5A, 1'b1, -1, FRAME);
    idle(C);
    check_events("b2b");

    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (busy) busy_cnt++;
    end
    rx = 1'b1;
    for (int i = 0; i < 4 * C; i++) begin
      tick(1);
      if (busy) busy_cnt++;
    end
    chk("false_start_busy_max", 64'(busy_cnt <= HALF + 2), 64'd1);
    chk("false_start_busy_seen", 64'(busy_cnt > 0), 64'd1);
    check_events("false_start");

    send(8'h3C, 1'b0, -1, FRAME);
    busy_cnt = 0;
    rx = 1'b0;
    for (int i = 0; i < 40 * C; i++) begin
      tick(1);
      if (busy) busy_cnt++;
    end
    check_events("frame_err");
    chk("frame_err_hold_byte", 64'(rx_byte), 64'(last_good));
    chk("break_no_retrigger", 64'(busy_cnt), 64'd0);
    idle(2 * C);
    send(8'h81, 1'b1, -1, FRAME);
    idle(C);
    check_events("after_break");

    send(8'h66, 1'b1, -1, 5 * C + C / 2);
    rst = 1'b1;
    rx  = 1'b1;
    tick(2);
    chk("midrst_byte", 64'(rx_byte), 64'h00);
    chk("midrst_rdy",  64'(rdy),     64'd0);
    chk("midrst_busy", 64'(busy),    64'd0);
    chk("midrst_ferr", 64'(ferr),    64'd0);
    rst = 1'b0;
    last_good = 8'h00;
    idle(2 * C);
    check_events("midrst_none");
    send(8'h7E, 1'b1, -1, FRAME);
    idle(C);
    check_events("after_rst");

    for (int g = 0; g < 4; g++) begin
      d = 8'($urandom);
      k = int'($urandom_range(0, 7));
      send(d, 1'b1, k, FRAME);
      idle(C);
    end
    check_events("glitch");

    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      send(8'(perm[i]), 1'b1, -1, FRAME);
      idle(int'($urandom_range(0, 3)));
    end
    idle(C);
    check_events("loopback");
    chk("final_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
